// File: rtl/alu_sequencer.sv
// Register-file sequencer driving an external combinational ALU: IDLE -> READ -> EXEC -> WB.
// Optional sticky overflow flag enabled by defining ALU_SEQ_STICKY_OVF_EN.

package alu_sequencer_pkg;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_W    = 2;
  localparam int unsigned SH_W     = 3;
  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned NUM_REGS = 4;

  localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(4'h9);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [SH_W-1:0]   shamt;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;
endpackage

module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_W-1:0]  cmd_rd,
  input  logic [REG_W-1:0]  cmd_rs,
  input  logic [REG_W-1:0]  cmd_rt,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_use_imm,
  input  logic [SH_W-1:0]   cmd_shamt,
  output logic [OP_W-1:0]   alu_fs,
  output logic [SH_W-1:0]   alu_shift,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] status,
  input  logic [REG_W-1:0]  dbg_rsel,
  output logic [DATA_W-1:0] dbg_rdata
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  input  logic              clr_sticky,
  output logic              sticky_ovf
`endif
);

  state_t state, next_state;
  cmd_t   cmd_in, cmd_q;
  logic   accept;
  logic   done_d, err_d, ready_d;

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign cmd_in    = {cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, cmd_use_imm, cmd_shamt};
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_rdata = regs[dbg_rsel];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next state and next values of the registered handshake/pulse outputs
  always_comb begin
    next_state = state;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ready_d    = 1'b0;
    case (state)
      S_IDLE: if (accept) next_state = (cmd_op <= OP_LAST_LEGAL) ? S_READ : S_ERR;
      S_READ: next_state = S_EXEC;
      S_EXEC: next_state = S_WB;
      S_WB:   next_state = S_IDLE;
      S_ERR:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    done_d  = (next_state == S_WB);
    err_d   = (next_state == S_ERR);
    ready_d = (next_state == S_IDLE);
  end

  // Datapath: command latch, ALU operand launch, result capture, writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      alu_fs    <= '0;
      alu_shift <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      result    <= '0;
      status    <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      cmd_ready <= ready_d;
      done      <= done_d;
      err       <= err_d;
      if (state == S_IDLE && accept) cmd_q <= cmd_in;
      if (state == S_READ) begin
        alu_fs    <= cmd_q.op;
        alu_shift <= cmd_q.shamt;
        alu_a     <= regs[cmd_q.rs];
        alu_b     <= cmd_q.use_imm ? cmd_q.imm : regs[cmd_q.rt];
      end
      if (state == S_EXEC) begin
        result <= alu_f;
        status <= {alu_ovf, alu_carry, alu_neg, alu_zero};
      end
      if (state == S_WB) regs[cmd_q.rd] <= result;
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  // Overflow capture takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sticky_ovf <= 1'b0;
    else if (state == S_EXEC && alu_ovf) sticky_ovf <= 1'b1;
    else if (clr_sticky)                 sticky_ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the alu_* side.
// Sticky-overflow checks are compiled when ALU_SEQ_STICKY_OVF_EN is defined.

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt;
  logic [7:0] cmd_imm;
  logic       cmd_use_imm;
  logic [2:0] cmd_shamt;
  logic [3:0] alu_fs;
  logic [2:0] alu_shift;
  logic [7:0] alu_a, alu_b, alu_f;
  logic       alu_zero, alu_neg, alu_carry, alu_ovf;
  logic       done, err;
  logic [7:0] result;
  logic [3:0] status;
  logic [1:0] dbg_rsel;
  logic [7:0] dbg_rdata;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic       clr_sticky, sticky_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .cmd_use_imm(cmd_use_imm), .cmd_shamt(cmd_shamt),
    .alu_fs(alu_fs), .alu_shift(alu_shift), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .done(done), .err(err), .result(result), .status(status),
    .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
`ifdef ALU_SEQ_STICKY_OVF_EN
    , .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf)
`endif
  );

  // Behavioural ALU: 0 ADD, 2 SUB (carry = no borrow), 5 OR, 6 SHL; others pass A
  logic [8:0] alu_t;
  always_comb begin
    alu_t     = '0;
    alu_f     = alu_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_fs)
      4'h0: begin
        alu_t     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f     = alu_t[7:0];
        alu_carry = alu_t[8];
        alu_ovf   = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
      end
      4'h2: begin
        alu_t     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_f     = alu_t[7:0];
        alu_carry = ~alu_t[8];
        alu_ovf   = (alu_a[7] != alu_b[7]) && (alu_f[7] != alu_a[7]);
      end
      4'h5: alu_f = alu_a | alu_b;
      4'h6: begin
        alu_t     = {1'b0, alu_a} << alu_shift;
        alu_f     = alu_t[7:0];
        alu_carry = alu_t[8];
      end
      default: alu_f = alu_a;
    endcase
    alu_zero = (alu_f == 8'h00);
    alu_neg  = alu_f[7];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_rsel = idx;
    #1;
    val = dbg_rdata;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command; report the post-accept cycle (1 = READ) in which done appeared
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [7:0] imm, input logic use_imm,
                         input logic [2:0] sh, input logic clr_exec,
                         output int done_cyc, output logic [7:0] a_ex, output logic [7:0] b_ex);
    wait_ready();
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    cmd_imm = imm; cmd_use_imm = use_imm; cmd_shamt = sh;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    done_cyc = 0;
    a_ex = 8'hxx;
    b_ex = 8'hxx;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        a_ex = alu_a;
        b_ex = alu_b;
      end
`ifdef ALU_SEQ_STICKY_OVF_EN
      if (c == 2 && clr_exec) clr_sticky = 1'b1;
      if (c == 3) clr_sticky = 1'b0;
`else
      if (clr_exec && c == 0) done_cyc = -1;
`endif
      if (done && done_cyc == 0) done_cyc = c;
      @(posedge clk); #1;
    end
  endtask

  int         dc;
  logic [7:0] a_ex, b_ex, v;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
    cmd_imm = '0; cmd_use_imm = 1'b0; cmd_shamt = '0; dbg_rsel = '0;
`ifdef ALU_SEQ_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_status", 32'(status), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h00);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check("rst_reg", 32'(v), 32'h00);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // OR r0 | 0x7F -> r1
    run_cmd(4'h5, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 3'd0, 1'b0, dc, a_ex, b_ex);
    check("or_done_cycle", 32'(dc), 32'd3);
    read_reg(2'd1, v);
    check("or_r1", 32'(v), 32'h7F);
    check("or_status", 32'(status), 32'b0000);

    // ADD r1 + 1 -> r2: signed overflow into 0x80
    run_cmd(4'h0, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 3'd0, 1'b0, dc, a_ex, b_ex);
    check("add_done_cycle", 32'(dc), 32'd3);
    read_reg(2'd2, v);
    check("add_r2", 32'(v), 32'h80);
    check("add_status", 32'(status), 32'b1010);

    // SUB r1 - r1 -> r3
    run_cmd(4'h2, 2'd3, 2'd1, 2'd1, 8'hAA, 1'b0, 3'd0, 1'b0, dc, a_ex, b_ex);
    check("sub_alu_a_exec", 32'(a_ex), 32'h7F);
    check("sub_alu_b_exec", 32'(b_ex), 32'h7F);
    check("sub_alu_a_hold", 32'(alu_a), 32'h7F);
    read_reg(2'd3, v);
    check("sub_r3", 32'(v), 32'h00);
    check("sub_status", 32'(status), 32'b0101);

    // Illegal op with cmd_valid held
    wait_ready();
    cmd_op = 4'hB; cmd_rd = 2'd1; cmd_rs = 2'd2; cmd_use_imm = 1'b1; cmd_imm = 8'h55;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    check("ill_err", 32'(err), 32'd1);
    check("ill_busy", 32'(cmd_ready), 32'd0);
    check("ill_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("ill_err_pulse", 32'(err), 32'd0);
    check("ill_ready_back", 32'(cmd_ready), 32'd1);
    check("ill_no_done2", 32'(done), 32'd0);
    check("ill_status", 32'(status), 32'b0101);
    check("ill_result", 32'(result), 32'h00);
    read_reg(2'd1, v); check("ill_r1", 32'(v), 32'h7F);
    read_reg(2'd2, v); check("ill_r2", 32'(v), 32'h80);

    // SHL r1 by 1 -> r0
    run_cmd(4'h6, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 3'd1, 1'b0, dc, a_ex, b_ex);
    read_reg(2'd0, v);
    check("shl_r0", 32'(v), 32'hFE);
    check("shl_status", 32'(status), 32'b0010);

    // Reset during EXEC of ADD -> r2
    wait_ready();
    cmd_op = 4'h0; cmd_rd = 2'd2; cmd_rs = 2'd1; cmd_imm = 8'h01; cmd_use_imm = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    read_reg(2'd2, v);
    check("abort_r2", 32'(v), 32'h00);
    check("abort_ready_low", 32'(cmd_ready), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'h00);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    check("abort_no_done_after", 32'(done), 32'd0);
    read_reg(2'd2, v);
    check("abort_r2_after", 32'(v), 32'h00);

`ifdef ALU_SEQ_STICKY_OVF_EN
    check("sticky_rst", 32'(sticky_ovf), 32'd0);
    run_cmd(4'h5, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 3'd0, 1'b0, dc, a_ex, b_ex);
    check("sticky_after_or", 32'(sticky_ovf), 32'd0);
    run_cmd(4'h0, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 3'd0, 1'b0, dc, a_ex, b_ex);
    check("sticky_set", 32'(sticky_ovf), 32'd1);
    run_cmd(4'h5, 2'd3, 2'd0, 2'd0, 8'h01, 1'b1, 3'd0, 1'b0, dc, a_ex, b_ex);
    check("sticky_hold", 32'(sticky_ovf), 32'd1);
    @(negedge clk) clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_clr", 32'(sticky_ovf), 32'd0);
    run_cmd(4'h0, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 3'd0, 1'b1, dc, a_ex, b_ex);
    check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 4 (ALU function code); cmd_rd, cmd_rs, cmd_rt in 2 each (register indices); cmd_imm in 8; cmd_use_imm in 1; cmd_shamt in 3.
REQ-003 SHALL have ALU-facing ports: alu_fs out 4; alu_shift out 3; alu_a out 8; alu_b out 8; alu_f in 8; alu_zero, alu_neg, alu_carry, alu_ovf in 1 each.
REQ-004 SHALL have result ports: done out 1 (one-cycle pulse); err out 1 (one-cycle pulse); result out 8 (last written value); status out 4 = {ovf, carry, neg, zero}; dbg_rsel in 2; dbg_rdata out 8 (combinational read of register dbg_rsel).

Function
REQ-005 SHALL contain four 8-bit registers r0..r3, all writable.
REQ-006 SHALL run FSM IDLE -> READ -> EXEC -> WB -> IDLE for legal ops; IDLE -> ERR -> IDLE for illegal ops.
REQ-007 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge with cmd_valid=1 and cmd_ready=1, latching all cmd_* fields.
REQ-008 Legal cmd_op values SHALL be 4'h0..4'h9; 4'hA..4'hF SHALL be illegal.
REQ-009 In READ, alu_fs, alu_shift, alu_a (= r[rs]) and alu_b (= cmd_use_imm ? imm : r[rt]) SHALL be registered and held stable through EXEC.
REQ-010 At the end of EXEC, alu_f SHALL be captured into result and the four ALU flags into status.
REQ-011 In WB, r[rd] SHALL be written with the captured result and done SHALL be 1 for exactly that cycle; latency = 3 cycles from accept edge to done.
REQ-012 In ERR, err SHALL be 1 for one cycle; no register, result or status change.
REQ-013 Outside READ/EXEC, alu_* outputs SHALL hold their last values (no toggling).
REQ-014 cmd_valid while busy SHALL be ignored; back-to-back commands SHALL be accepted no sooner than the cycle after WB/ERR (min 4-cycle issue interval).
REQ-015 Operands SHALL be sampled in READ, so a command reading the rd of the previous command sees the written value.
REQ-016 dbg_rdata SHALL reflect a WB write from the following cycle onward.

Reset
REQ-017 rst_n low SHALL asynchronously force: FSM IDLE; r0..r3 = 8'h00; result = 8'h00; status = 4'h0; done = 0; err = 0; alu_fs = 4'h0; alu_shift = 3'h0; alu_a = alu_b = 8'h00; cmd_ready = 0 while asserted, 1 on first cycle after release.
REQ-018 Reset asserted mid-operation SHALL abort the command with no writeback and no done/err pulse.

Configuration
REQ-019 Macro ALU_SEQ_STICKY_OVF_EN defined: SHALL add input clr_sticky (1) and output sticky_ovf (1, reset 0); sticky_ovf sets when a legal op captures alu_ovf=1, clears on clr_sticky=1; simultaneous set and clear -> set wins.
REQ-020 Macro undefined: ports clr_sticky and sticky_ovf SHALL not exist; all other behaviour identical.

Verification
REQ-021 Reset, then op=5 (OR), rs=0, imm=8'h7F, use_imm=1, rd=1 -> done 3 cycles after accept, r1=8'h7F, status=4'b0000.
REQ-022 Then op=0 (ADD), rs=1, imm=8'h01, use_imm=1, rd=2 -> r2=8'h80, status ovf=1, neg=1, zero=0.
REQ-023 op=2 (SUB), rs=1, rt=1, use_imm=0, rd=3 -> r3=8'h00, zero=1; alu_a=alu_b=8'h7F held through EXEC.
REQ-024 op=4'hB with cmd_valid held -> err pulse 1 cycle after accept, no done, r0..r3 and status unchanged, cmd_ready back to 1 next cycle.
REQ-025 Assert rst_n low during EXEC of an ADD to r2 -> r2=8'h00, no done pulse, cmd_ready=1 one cycle after release.
REQ-026 With ALU_SEQ_STICKY_OVF_EN: repeat REQ-022 then an OR with no overflow -> sticky_ovf stays 1; clr_sticky pulse -> 0; clr_sticky in the same cycle as an overflowing capture -> 1.
